ddr3_test_pattern_generator: RTL and testbench
==============================================

# ddr3_test_pattern_generator

Self-checking traffic source that sits directly upstream of `ddr3_memory_controller` on its user interface. On `start`, it writes a deterministic data pattern to a contiguous address range. It then reads the range back and compares every returned word against the expected pattern. It reports completion, pass/fail, an error count and the first failing address, for board bring-up and ILA observation.

## Interface

- `ADDRESS_BITWIDTH`, 15: DDR3 row/column address width.
- `BANK_ADDRESS_BITWIDTH`, 3: bank address width.
- `DQ_BITWIDTH`, 16: user data word width; must be ≥ 2.
- `NUM_WORDS`, 256: words written and read per run; range 1 … 2^(`BANK_ADDRESS_BITWIDTH`+`ADDRESS_BITWIDTH`).
- `PATTERN_SEED`, 16'hA5C3: XOR seed for the data pattern; the low `DQ_BITWIDTH` bits are used.
- `MAX_OUTSTANDING`, 8: maximum number of accepted reads whose data has not yet returned; range 1 … 255.

Ports (UA = `BANK_ADDRESS_BITWIDTH`+`ADDRESS_BITWIDTH`):

- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  single-cycle run request.
- `cmd_ready`  in  1  controller accepts the presented command this cycle.
- `write_enable`  out  1  write command valid.
- `read_enable`  out  1  read command valid.
- `i_user_data_address`  out  UA  command address.
- `i_user_data`  out  `DQ_BITWIDTH`  write data.
- `rd_valid`  in  1  `o_user_data` holds returned read data this cycle.
- `o_user_data`  in  `DQ_BITWIDTH`  read data from the controller, returned in request order.
- `busy`  out  1  run in progress.
- `done`  out  1  run complete; held until the next accepted `start` or `reset`.
- `pass`  out  1  valid while `done`=1: high when no mismatches occurred.
- `error_count`  out  16  number of mismatches; saturates at 16'hFFFF.
- `first_error_address`  out  UA  address of the first mismatch.

## Operation

- Expected data for address `a`: `({16{1'b0}},a)[DQ_BITWIDTH-1:0] ^ PATTERN_SEED[DQ_BITWIDTH-1:0]`, i.e. address zero-extended or truncated to `DQ_BITWIDTH`.
- States: IDLE, WRITE, READ, DRAIN, DONE.
- IDLE/DONE:
  - `start`=1 clears `error_count`, `first_error_address`, `done` and `pass`.
  - It then loads the issue address to 0 and enters WRITE.
- WRITE:
  - Drive `write_enable`=1, the current address and its pattern.
  - A command transfers on a cycle with `write_enable`&`cmd_ready`; the address then increments.
  - The transfer of address `NUM_WORDS-1` moves the block to READ.
- READ:
  - Issue-address counter restarts at 0.
  - `read_enable`=1 only while outstanding < `MAX_OUTSTANDING`.
  - A read transfers on `read_enable`&`cmd_ready`.
  - The transfer of address `NUM_WORDS-1` moves the block to DRAIN.
- Check counter: a separate counter starting at 0 supplies the expected address.
  - Every `rd_valid` with outstanding > 0 compares `o_user_data` to the expected pattern, increments the check counter and decrements outstanding.
  - `rd_valid` with outstanding = 0 is ignored.
- On a mismatch, `error_count` increments (saturating). If `error_count` was 0, `first_error_address` captures the check address.
- Read accepted and data returned in the same cycle: outstanding is unchanged.
- DRAIN: when the check counter has consumed `NUM_WORDS` words, go to DONE.
- `write_enable` and `read_enable` are never high together.
- `start` while `busy`=1 is ignored.

## Timing

- All outputs are registered.
- Reset values: `write_enable`, `read_enable`, `busy`, `done`, `pass` = 0; `i_user_data_address`, `i_user_data`, `error_count`, `first_error_address` = 0; state IDLE; outstanding and check counters 0.
- `start` sampled in cycle k:
  - `busy`=1 and `write_enable`=1 with address 0 in cycle k+1.
  - With `cmd_ready` held at 1, one write per cycle, so `NUM_WORDS` writes occupy cycles k+1 … k+`NUM_WORDS`.
- The first `read_enable` appears in the cycle after the last write transfer; there is no bubble beyond that one cycle.
- Command handshake: while `cmd_ready`=0, the enable, address and data hold stable.
- The final `rd_valid` is in cycle m. In cycle m+1:
  - `done`=1, `busy`=0, and `pass`=(`error_count`==0), including that final comparison.
- Address arithmetic is UA-bit; `NUM_WORDS` = 2^UA wraps the counter to 0 exactly at the transition out of WRITE/READ.
- `reset` mid-run aborts immediately: the next cycle shows reset values. Reads still in flight in the controller are ignored afterwards because outstanding = 0.

## Test plan

- `NUM_WORDS`=4, `cmd_ready`=1, loopback memory model with 3-cycle read latency → writes to addresses 0..3 with data A5C3, A5C2, A5C1, A5C0; then 4 reads; `done`=1, `pass`=1, `error_count`=0.
- Same, with the model corrupting address 2 (bit 0 flipped) → `error_count`=1, `first_error_address`=2, `pass`=0.
- `MAX_OUTSTANDING`=2, read latency 10 → `read_enable` deasserts after 2 accepted reads and reasserts the cycle after the first `rd_valid`; all data checks pass.
- `cmd_ready` toggled pseudo-randomly → address and data stable during stalls; exactly `NUM_WORDS` writes and `NUM_WORDS` reads transferred.
- `start` pulsed while `busy`, plus a spurious `rd_valid` in IDLE → both ignored; no counter changes.
- `reset` asserted during READ with 3 reads outstanding → next cycle all outputs at reset values; later `rd_valid` pulses are ignored; a new `start` completes with `pass`=1.

Source files
------------

// File: rtl/ddr3_test_pattern_generator_if.sv
// Command/data bus between the pattern generator (master) and the DDR3 controller user port (slave).
interface ddr3_test_pattern_generator_if #(
    parameter int ADDRESS_BITWIDTH      = 15,
    parameter int BANK_ADDRESS_BITWIDTH = 3,
    parameter int DQ_BITWIDTH           = 16
);
    localparam int UA = BANK_ADDRESS_BITWIDTH + ADDRESS_BITWIDTH;

    logic                   cmd_ready;
    logic                   write_enable;
    logic                   read_enable;
    logic [UA-1:0]          i_user_data_address;
    logic [DQ_BITWIDTH-1:0] i_user_data;
    logic                   rd_valid;
    logic [DQ_BITWIDTH-1:0] o_user_data;

    modport master (
        input  cmd_ready,
        input  rd_valid,
        input  o_user_data,
        output write_enable,
        output read_enable,
        output i_user_data_address,
        output i_user_data
    );

    modport slave (
        output cmd_ready,
        output rd_valid,
        output o_user_data,
        input  write_enable,
        input  read_enable,
        input  i_user_data_address,
        input  i_user_data
    );
endinterface

// File: rtl/ddr3_test_pattern_generator.sv
// Writes an address-derived pattern to a contiguous range, reads it back in order and
// reports pass/fail, a saturating mismatch count and the first failing address.
module ddr3_test_pattern_generator #(
    parameter int          ADDRESS_BITWIDTH      = 15,
    parameter int          BANK_ADDRESS_BITWIDTH = 3,
    parameter int          DQ_BITWIDTH           = 16,
    parameter int          NUM_WORDS             = 256,
    parameter logic [15:0] PATTERN_SEED          = 16'hA5C3,
    parameter int          MAX_OUTSTANDING       = 8
) (
    input  logic                                             clk,
    input  logic                                             reset,
    input  logic                                             start,
    ddr3_test_pattern_generator_if.master                    bus,
    output logic                                             busy,
    output logic                                             done,
    output logic                                             pass,
    output logic [15:0]                                      error_count,
    output logic [BANK_ADDRESS_BITWIDTH+ADDRESS_BITWIDTH-1:0] first_error_address
);
    localparam int                     UA         = BANK_ADDRESS_BITWIDTH + ADDRESS_BITWIDTH;
    localparam logic [UA-1:0]          LAST_ADDR  = UA'(NUM_WORDS - 1);
    localparam logic [UA:0]            LAST_CHECK = (UA+1)'(NUM_WORDS - 1);
    localparam logic [7:0]             MAX_OUT    = 8'(MAX_OUTSTANDING);
    localparam logic [DQ_BITWIDTH-1:0] SEED       = DQ_BITWIDTH'(PATTERN_SEED);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    // Address is zero-extended or truncated to the data width before the seed is applied.
    function automatic logic [DQ_BITWIDTH-1:0] patternOf(input logic [UA-1:0] addr);
        return DQ_BITWIDTH'(addr) ^ SEED;
    endfunction

    state_t                 r_state;
    logic                   r_writeEnable;
    logic                   r_readEnable;
    logic [UA-1:0]          r_address;
    logic [DQ_BITWIDTH-1:0] r_data;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_pass;
    logic [15:0]            r_errorCount;
    logic [UA-1:0]          r_firstErrorAddress;
    logic [7:0]             r_outstanding;
    logic [UA:0]            r_checkCount;

    state_t                 w_nextState;
    logic                   w_nextWriteEnable;
    logic                   w_nextReadEnable;
    logic [UA-1:0]          w_nextAddress;
    logic [DQ_BITWIDTH-1:0] w_nextData;
    logic                   w_nextBusy;
    logic                   w_nextDone;
    logic                   w_nextPass;
    logic [15:0]            w_nextErrorCount;
    logic [UA-1:0]          w_nextFirstErrorAddress;
    logic [7:0]             w_nextOutstanding;
    logic [UA:0]            w_nextCheckCount;

    logic                   w_writeXfer;
    logic                   w_readXfer;
    logic                   w_returned;
    logic [UA-1:0]          w_checkAddr;
    logic                   w_mismatch;

    // Returned data only counts while a read is actually in flight; stale returns after an abort are dropped.
    assign w_writeXfer = r_writeEnable & bus.cmd_ready;
    assign w_readXfer  = r_readEnable & bus.cmd_ready;
    assign w_returned  = bus.rd_valid & (r_outstanding != 8'd0);
    assign w_checkAddr = r_checkCount[UA-1:0];
    assign w_mismatch  = w_returned & (bus.o_user_data != patternOf(w_checkAddr));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState             = r_state;
        w_nextWriteEnable       = r_writeEnable;
        w_nextReadEnable        = r_readEnable;
        w_nextAddress           = r_address;
        w_nextData              = r_data;
        w_nextBusy              = r_busy;
        w_nextDone              = r_done;
        w_nextPass              = r_pass;
        w_nextErrorCount        = r_errorCount;
        w_nextFirstErrorAddress = r_firstErrorAddress;
        w_nextOutstanding       = r_outstanding;
        w_nextCheckCount        = r_checkCount;

        if (w_readXfer && !w_returned) begin
            w_nextOutstanding = r_outstanding + 8'd1;
        end else if (!w_readXfer && w_returned) begin
            w_nextOutstanding = r_outstanding - 8'd1;
        end

        if (w_returned) begin
            w_nextCheckCount = r_checkCount + (UA+1)'(1);
            if (w_mismatch) begin
                if (r_errorCount != 16'hFFFF) begin
                    w_nextErrorCount = r_errorCount + 16'd1;
                end
                if (r_errorCount == 16'd0) begin
                    w_nextFirstErrorAddress = w_checkAddr;
                end
            end
        end

        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_nextState             = S_WRITE;
                    w_nextWriteEnable       = 1'b1;
                    w_nextReadEnable        = 1'b0;
                    w_nextAddress           = '0;
                    w_nextData              = patternOf('0);
                    w_nextBusy              = 1'b1;
                    w_nextDone              = 1'b0;
                    w_nextPass              = 1'b0;
                    w_nextErrorCount        = 16'd0;
                    w_nextFirstErrorAddress = '0;
                    w_nextOutstanding       = 8'd0;
                    w_nextCheckCount        = '0;
                end
            end
            S_WRITE: begin
                if (w_writeXfer) begin
                    if (r_address == LAST_ADDR) begin
                        w_nextState       = S_READ;
                        w_nextWriteEnable = 1'b0;
                        w_nextReadEnable  = 1'b1;
                        w_nextAddress     = '0;
                    end else begin
                        w_nextAddress = r_address + UA'(1);
                        w_nextData    = patternOf(r_address + UA'(1));
                    end
                end
            end
            S_READ: begin
                // Enable is registered, so it is derived from the outstanding count it will see next cycle.
                if (w_readXfer) begin
                    w_nextAddress = r_address + UA'(1);
                end
                if (w_readXfer && (r_address == LAST_ADDR)) begin
                    w_nextState      = S_DRAIN;
                    w_nextReadEnable = 1'b0;
                end else begin
                    w_nextReadEnable = (w_nextOutstanding < MAX_OUT);
                end
            end
            S_DRAIN: begin
                if (w_returned && (r_checkCount == LAST_CHECK)) begin
                    w_nextState = S_DONE;
                    w_nextBusy  = 1'b0;
                    w_nextDone  = 1'b1;
                    w_nextPass  = (w_nextErrorCount == 16'd0);
                end
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_writeEnable       <= 1'b0;
            r_readEnable        <= 1'b0;
            r_address           <= '0;
            r_data              <= '0;
            r_busy              <= 1'b0;
            r_done              <= 1'b0;
            r_pass              <= 1'b0;
            r_errorCount        <= 16'd0;
            r_firstErrorAddress <= '0;
            r_outstanding       <= 8'd0;
            r_checkCount        <= '0;
        end else begin
            r_writeEnable       <= w_nextWriteEnable;
            r_readEnable        <= w_nextReadEnable;
            r_address           <= w_nextAddress;
            r_data              <= w_nextData;
            r_busy              <= w_nextBusy;
            r_done              <= w_nextDone;
            r_pass              <= w_nextPass;
            r_errorCount        <= w_nextErrorCount;
            r_firstErrorAddress <= w_nextFirstErrorAddress;
            r_outstanding       <= w_nextOutstanding;
            r_checkCount        <= w_nextCheckCount;
        end
    end

    assign bus.write_enable        = r_writeEnable;
    assign bus.read_enable         = r_readEnable;
    assign bus.i_user_data_address = r_address;
    assign bus.i_user_data         = r_data;
    assign busy                    = r_busy;
    assign done                    = r_done;
    assign pass                    = r_pass;
    assign error_count             = r_errorCount;
    assign first_error_address     = r_firstErrorAddress;
endmodule

// File: tb/tb_ddr3_test_pattern_generator.sv
// Bench for ddr3_test_pattern_generator: a loopback controller model with configurable latency,
// stalls and corruption, with run results predicted from the pattern rule and the corruption mask.
module tb_ddr3_test_pattern_generator;
    localparam int          ADDR_W = 15;
    localparam int          BANK_W = 3;
    localparam int          DQ_W   = 16;
    localparam int          UA     = ADDR_W + BANK_W;
    localparam int          NW     = 8;
    localparam int          MAXO   = 3;
    localparam logic [15:0] SEED   = 16'hA5C3;

    typedef struct {
        int addr;
        int due;
        bit stale;
    } pend_t;

    logic          clk   = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          busy;
    logic          done;
    logic          pass;
    logic [15:0]   error_count;
    logic [UA-1:0] first_error_address;

    ddr3_test_pattern_generator_if #(
        .ADDRESS_BITWIDTH(ADDR_W),
        .BANK_ADDRESS_BITWIDTH(BANK_W),
        .DQ_BITWIDTH(DQ_W)
    ) busIf ();

    ddr3_test_pattern_generator #(
        .ADDRESS_BITWIDTH(ADDR_W),
        .BANK_ADDRESS_BITWIDTH(BANK_W),
        .DQ_BITWIDTH(DQ_W),
        .NUM_WORDS(NW),
        .PATTERN_SEED(SEED),
        .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .bus(busIf),
        .busy(busy),
        .done(done),
        .pass(pass),
        .error_count(error_count),
        .first_error_address(first_error_address)
    );

    initial forever #5 clk = ~clk;

    int          nTests = 0;
    int          nFail  = 0;
    int          cyc    = 0;
    int          readyPct = 100;
    int          latency  = 3;
    logic [7:0]  corruptMask = 8'h00;
    bit          spurious = 1'b0;
    int          writeCnt = 0, readCnt = 0, tbOut = 0, maxOutSeen = 0;
    int          firstWriteCyc = -1, lastWriteCyc = -1, firstReadCyc = -1, lastRetCyc = -1;
    int          startCyc = 0, doneCyc = 0;
    logic [15:0] mem [0:255];
    pend_t       pend [$];
    pend_t       headItem;
    bit          prevStalled = 1'b0;
    logic        prevWe, prevRe;
    logic [UA-1:0] prevAddr;
    logic [15:0] prevData;
    int          mAddr, outBefore, acc, ret;

    function automatic logic [15:0] expectedWord(input int a);
        return 16'(a) ^ SEED;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nTests++;
        assert (observed === expected) else begin
            nFail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic waitCycle();
        @(negedge clk);
        #1;
    endtask

    // Loopback controller: decides cmd_ready and returned data on each falling edge.
    initial begin : controllerModel
        busIf.cmd_ready   = 1'b0;
        busIf.rd_valid    = 1'b0;
        busIf.o_user_data = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                tbOut = 0; writeCnt = 0; readCnt = 0; prevStalled = 1'b0;
                foreach (pend[i]) pend[i].stale = 1'b1;
            end
            checkOutput("exclusiveEnables", 32'(busIf.write_enable & busIf.read_enable), 0);
            checkOutput("readEnableThrottle", 32'(busIf.read_enable),
                        32'((writeCnt == NW) && (readCnt < NW) && (tbOut < MAXO)));
            if (prevStalled) begin
                checkOutput("stallWe", 32'(busIf.write_enable), 32'(prevWe));
                checkOutput("stallRe", 32'(busIf.read_enable), 32'(prevRe));
                checkOutput("stallAddr", 32'(busIf.i_user_data_address), 32'(prevAddr));
                checkOutput("stallData", 32'(busIf.i_user_data), 32'(prevData));
            end
            busIf.cmd_ready = ($urandom_range(99) < readyPct);
            outBefore = tbOut;
            acc = 0;
            ret = 0;
            mAddr = int'(busIf.i_user_data_address);
            if (busIf.write_enable && busIf.cmd_ready) begin
                checkOutput("writeAddr", mAddr, writeCnt);
                checkOutput("writeData", 32'(busIf.i_user_data), 32'(expectedWord(mAddr)));
                mem[mAddr[7:0]] = busIf.i_user_data;
                if (writeCnt == 0) firstWriteCyc = cyc;
                lastWriteCyc = cyc;
                writeCnt++;
            end
            if (busIf.read_enable && busIf.cmd_ready) begin
                checkOutput("readAddr", mAddr, readCnt);
                if (readCnt == 0) firstReadCyc = cyc;
                pend.push_back('{addr: mAddr, due: cyc + latency, stale: 1'b0});
                readCnt++;
                acc = 1;
            end
            if (pend.size() > 0 && pend[0].due <= cyc) begin
                headItem = pend.pop_front();
                busIf.rd_valid = 1'b1;
                if (headItem.stale)
                    busIf.o_user_data = ~expectedWord(headItem.addr);
                else
                    busIf.o_user_data = mem[headItem.addr[7:0]] ^ {15'b0, corruptMask[headItem.addr[2:0]]};
            end else if (spurious) begin
                busIf.rd_valid    = 1'b1;
                busIf.o_user_data = 16'h0BAD;
                spurious          = 1'b0;
            end else begin
                busIf.rd_valid = 1'b0;
            end
            if (busIf.rd_valid && outBefore > 0) begin
                ret = 1;
                lastRetCyc = cyc;
            end
            tbOut = outBefore + acc - ret;
            if (tbOut > maxOutSeen) maxOutSeen = tbOut;
            prevStalled = (busIf.write_enable || busIf.read_enable) && !busIf.cmd_ready;
            prevWe   = busIf.write_enable;
            prevRe   = busIf.read_enable;
            prevAddr = busIf.i_user_data_address;
            prevData = busIf.i_user_data;
        end
    end

    task automatic applyStimulus(input int pct, input int lat, input logic [7:0] mask);
        readyPct = pct; latency = lat; corruptMask = mask;
        writeCnt = 0; readCnt = 0; maxOutSeen = 0;
        firstWriteCyc = -1; lastWriteCyc = -1; firstReadCyc = -1; lastRetCyc = -1;
        startCyc = cyc;
        start = 1'b1;
        waitCycle();
        start = 1'b0;
    endtask

    task automatic waitDone(input int budget);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin
            waitCycle();
            n++;
        end
        checkOutput("doneWithinBudget", 32'(done), 1);
        doneCyc = cyc;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, ".we"}, 32'(busIf.write_enable), 0);
        checkOutput({tag, ".re"}, 32'(busIf.read_enable), 0);
        checkOutput({tag, ".addr"}, 32'(busIf.i_user_data_address), 0);
        checkOutput({tag, ".data"}, 32'(busIf.i_user_data), 0);
        checkOutput({tag, ".busy"}, 32'(busy), 0);
        checkOutput({tag, ".done"}, 32'(done), 0);
        checkOutput({tag, ".pass"}, 32'(pass), 0);
        checkOutput({tag, ".errCount"}, 32'(error_count), 0);
        checkOutput({tag, ".firstErr"}, 32'(first_error_address), 0);
    endtask

    // Results follow from the mask alone: reads return in address order, so the lowest corrupted address is first.
    task automatic checkRun(input string tag, input logic [7:0] mask);
        int errs = 0;
        int first = 0;
        bit found = 1'b0;
        for (int a = 0; a < NW; a++) begin
            if (mask[a]) begin
                errs++;
                if (!found) begin
                    first = a;
                    found = 1'b1;
                end
            end
        end
        checkOutput({tag, ".done"}, 32'(done), 1);
        checkOutput({tag, ".busy"}, 32'(busy), 0);
        checkOutput({tag, ".pass"}, 32'(pass), 32'(errs == 0));
        checkOutput({tag, ".errCount"}, 32'(error_count), errs);
        checkOutput({tag, ".firstErr"}, 32'(first_error_address), first);
        checkOutput({tag, ".writes"}, writeCnt, NW);
        checkOutput({tag, ".reads"}, readCnt, NW);
        checkOutput({tag, ".doneLatency"}, doneCyc, lastRetCyc + 1);
    endtask

    initial begin : mainSequence
        int n;
        logic [7:0] mask;
        reset = 1'b1;
        repeat (3) waitCycle();
        checkResetValues("resetHeld");
        reset = 1'b0;
        waitCycle();
        checkResetValues("idle");

        applyStimulus(100, 3, 8'h00);
        checkOutput("first.busy", 32'(busy), 1);
        checkOutput("first.we", 32'(busIf.write_enable), 1);
        checkOutput("first.addr", 32'(busIf.i_user_data_address), 0);
        checkOutput("first.data", 32'(busIf.i_user_data), 32'h0000A5C3);
        waitDone(500);
        checkRun("clean", 8'h00);
        checkOutput("clean.writeStart", firstWriteCyc, startCyc + 1);
        checkOutput("clean.writeEnd", lastWriteCyc, startCyc + NW);
        checkOutput("clean.firstRead", firstReadCyc, lastWriteCyc + 1);

        applyStimulus(100, 3, 8'h04);
        waitDone(500);
        checkRun("corruptAddr2", 8'h04);

        applyStimulus(100, 10, 8'h00);
        waitDone(500);
        checkRun("longLatency", 8'h00);
        checkOutput("longLatency.maxOutstanding", maxOutSeen, MAXO);

        for (int i = 0; i < 5; i++) begin
            mask = 8'($urandom_range(0, 255));
            applyStimulus(int'($urandom_range(30, 100)), int'($urandom_range(1, 12)), mask);
            waitDone(2000);
            checkRun("random", mask);
        end

        applyStimulus(100, 3, 8'h00);
        repeat (4) waitCycle();
        start = 1'b1;
        waitCycle();
        start = 1'b0;
        waitDone(500);
        checkRun("startWhileBusy", 8'h00);
        spurious = 1'b1;
        repeat (3) waitCycle();
        checkOutput("spurious.done", 32'(done), 1);
        checkOutput("spurious.pass", 32'(pass), 1);
        checkOutput("spurious.errCount", 32'(error_count), 0);
        checkOutput("spurious.busy", 32'(busy), 0);

        applyStimulus(100, 10, 8'h00);
        n = 0;
        while (tbOut < 3 && n < 200) begin
            waitCycle();
            n++;
        end
        checkOutput("abort.outstanding", tbOut, 3);
        reset = 1'b1;
        waitCycle();
        checkResetValues("abort");
        reset = 1'b0;
        repeat (20) waitCycle();
        checkOutput("abort.staleIgnoredErr", 32'(error_count), 0);
        checkOutput("abort.staleIgnoredDone", 32'(done), 0);
        checkOutput("abort.staleIgnoredBusy", 32'(busy), 0);
        applyStimulus(100, 3, 8'h00);
        waitDone(500);
        checkRun("afterAbort", 8'h00);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end
endmodule
